// File: rtl/mem_din_fetch.sv
// Memory operand fetch: reads a 1- or 2-byte little-endian operand over a
// T1/T2/T3 bus cycle with wait-state insertion in T2.
module mem_din_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        word,
    input  logic [15:0] addr_in,
    input  logic [7:0]  mem_din,
    input  logic        mem_wait_n,
    output logic [15:0] mem_addr,
    output logic        mem_mreq_n,
    output logic        mem_rd_n,
    output logic        busy,
    output logic        done,
    output logic [7:0]  reg_mem_din_hi,
    output logic [7:0]  reg_mem_din_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    state_t state;
    logic   word_q;
    logic   phase;

    // Bus-cycle sequencer with registered strobes, address and operand bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            word_q         <= 1'b0;
            phase          <= 1'b0;
            mem_addr       <= 16'h0000;
            mem_mreq_n     <= 1'b1;
            mem_rd_n       <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            reg_mem_din_hi <= 8'h00;
            reg_mem_din_lo <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_q     <= word;
                        mem_addr   <= addr_in;
                        phase      <= 1'b0;
                        mem_mreq_n <= 1'b0;
                        mem_rd_n   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= T1;
                    end
                end
                T1: begin
                    mem_mreq_n <= 1'b0;
                    mem_rd_n   <= 1'b0;
                    state      <= T2;
                end
                T2: begin
                    // Wait states are unbounded: stay here while memory holds wait low
                    if (mem_wait_n) begin
                        state <= T3;
                    end
                end
                T3: begin
                    mem_mreq_n <= 1'b1;
                    mem_rd_n   <= 1'b1;
                    if (phase) begin
                        reg_mem_din_hi <= mem_din;
                    end else begin
                        reg_mem_din_lo <= mem_din;
                    end
                    // Byte operands are zero-extended so the high byte never goes stale
                    if (!word_q) begin
                        reg_mem_din_hi <= 8'h00;
                    end
                    if (word_q && !phase) begin
                        phase    <= 1'b1;
                        mem_addr <= mem_addr + 16'd1;
                        state    <= T1;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_din_fetch.sv
// Scoreboard bench for mem_din_fetch: stimulus pushes expected accesses and
// operands, a negedge monitor pops and compares as the DUT presents them.
module tb_mem_din_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        word;
    logic [15:0] addr_in;
    logic [7:0]  mem_din;
    logic        mem_wait_n;
    logic [15:0] mem_addr;
    logic        mem_mreq_n;
    logic        mem_rd_n;
    logic        busy;
    logic        done;
    logic [7:0]  reg_mem_din_hi;
    logic [7:0]  reg_mem_din_lo;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         cyc;
    } done_t;

    done_t       done_q[$];
    logic [15:0] acc_q[$];
    done_t       mon_d;
    logic [15:0] mon_a;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          saved_done;
    logic        prev_rd = 1'b1;

    // Simple memory: the first address of the operation returns b0, anything else b1
    logic [15:0] a_sel = 16'h0000;
    logic [7:0]  b0 = 8'h00;
    logic [7:0]  b1 = 8'h00;
    assign mem_din = (mem_addr == a_sel) ? b0 : b1;

    mem_din_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .word           (word),
        .addr_in        (addr_in),
        .mem_din        (mem_din),
        .mem_wait_n     (mem_wait_n),
        .mem_addr       (mem_addr),
        .mem_mreq_n     (mem_mreq_n),
        .mem_rd_n       (mem_rd_n),
        .busy           (busy),
        .done           (done),
        .reg_mem_din_hi (reg_mem_din_hi),
        .reg_mem_din_lo (reg_mem_din_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: check each access address on read-strobe fall and each operand on done
    always @(negedge clk) begin
        if (prev_rd === 1'b1 && mem_rd_n === 1'b0) begin
            if (acc_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_access: got addr %0h expected none", mem_addr);
            end else begin
                mon_a = acc_q.pop_front();
                chk("access_addr", 48'(mem_addr), 48'(mon_a));
            end
        end
        prev_rd = mem_rd_n;
        if (done === 1'b1) begin
            done_seen++;
            if (done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
            end else begin
                mon_d = done_q.pop_front();
                chk("done_lo", 48'(reg_mem_din_lo), 48'(mon_d.lo));
                chk("done_hi", 48'(reg_mem_din_hi), 48'(mon_d.hi));
                chk("done_cycle", 48'(cyc), 48'(mon_d.cyc));
            end
        end
    end

    // Issue one start request and push its expected accesses and result
    task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] lo_b,
                         input logic [7:0] hi_b, input int lat, input logic push_done,
                         input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        done_t d;
        a_sel   = a;
        b0      = lo_b;
        b1      = hi_b;
        addr_in = a;
        word    = w;
        start   = 1'b1;
        acc_q.push_back(a);
        if (w) acc_q.push_back(a + 16'd1);
        if (push_done) begin
            d.hi  = exp_hi;
            d.lo  = exp_lo;
            d.cyc = cyc + lat;
            done_q.push_back(d);
        end
    endtask

    // Step n cycles: check strobe level pat[k], then drive wait_n from wpat[k]
    task automatic run(input int n, input logic [15:0] pat, input logic [15:0] wpat);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("strobes_k%0d", k + 1), {46'd0, mem_mreq_n, mem_rd_n},
                {46'd0, pat[k], pat[k]});
            mem_wait_n = wpat[k];
        end
        mem_wait_n = 1'b1;
    endtask

    // Let outstanding expectations drain within a bounded number of cycles
    task automatic wait_idle();
        int budget = 60;
        while ((done_q.size() != 0 || acc_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", done_q.size() + acc_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        word       = 1'b0;
        addr_in    = 16'h0000;
        mem_wait_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state",
            {12'd0, busy, done, mem_mreq_n, mem_rd_n, mem_addr, reg_mem_din_hi, reg_mem_din_lo},
            {12'd0, 4'b0011, 16'h0000, 8'h00, 8'h00});
        reset = 1'b0;

        // Byte read at 1234: strobes low 3 cycles, done 4 cycles after start
        @(negedge clk);
        issue(16'h1234, 1'b0, 8'hA5, 8'h00, 4, 1'b1, 8'h00, 8'hA5);
        run(4, 16'h0008, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("idle_hold", {15'd0, done, busy, mem_addr, reg_mem_din_hi, reg_mem_din_lo},
            {15'd0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5});

        // Word read wrapping FFFF -> 0000, one strobe-high cycle between bytes
        issue(16'hFFFF, 1'b1, 8'h34, 8'h12, 7, 1'b1, 8'h12, 8'h34);
        run(7, 16'h0048, 16'hFFFF);
        chk("wrap_addr_hold", 48'(mem_addr), 48'h0000);

        // Byte read with 3 wait states in T2, wait_n also pulsed low in T1 and T3
        @(negedge clk);
        issue(16'h2000, 1'b0, 8'h5C, 8'h00, 7, 1'b1, 8'h00, 8'h5C);
        run(7, 16'h0040, 16'h0050);

        // Start held during a word read is ignored; start in done cycle is accepted
        @(negedge clk);
        issue(16'h3000, 1'b1, 8'hEF, 8'hBE, 7, 1'b1, 8'hBE, 8'hEF);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            addr_in = 16'h4000;
            start   = 1'b1;
            chk($sformatf("busy_k%0d", k), 48'(busy), 48'd1);
        end
        @(negedge clk);
        chk("done_pulse", 48'(done), 48'd1);
        issue(16'h5000, 1'b0, 8'h77, 8'h00, 4, 1'b1, 8'h00, 8'h77);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_t1", {30'd0, mem_addr, mem_rd_n, busy}, {30'd0, 16'h5000, 1'b0, 1'b1});
        wait_idle();

        // Reset during T2 of the high-byte phase aborts with no done pulse
        @(negedge clk);
        issue(16'h6000, 1'b1, 8'h11, 8'h22, 0, 1'b0, 8'h00, 8'h00);
        run(5, 16'h0008, 16'hFFFF);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_abort",
            {12'd0, busy, done, mem_mreq_n, mem_rd_n, mem_addr, reg_mem_din_hi, reg_mem_din_lo},
            {12'd0, 4'b0011, 16'h0000, 8'h00, 8'h00});
        reset      = 1'b0;
        saved_done = done_seen;
        repeat (6) @(negedge clk);
        chk("no_done_after_abort", 48'(done_seen), 48'(saved_done));

        // Recovery after reset
        issue(16'h0042, 1'b0, 8'h99, 8'h00, 4, 1'b1, 8'h00, 8'h99);
        run(4, 16'h0008, 16'hFFFF);

        wait_idle();
        chk("queues_drained", 48'(done_q.size() + acc_q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
